// File: rtl/mem_block_arbiter.sv
// Arbitrates the single block-wide main memory between icache fills and dcache fills/write-backs.
// Define MEM_ARB_ROUND_ROBIN_EN to make simultaneous requests alternate instead of favouring the dcache.
module mem_block_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int BLOCK_W = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait,
  output logic [2:0]         o_state
);

  // Handshake: a cache holds its request high until it samples busywait low;
  // busywait is low only in that requester's DONE cycle (or while reset is high).

  // Encoding is visible on o_state: 0 IDLE, 1 GNT_I, 2 GNT_D, 3 DONE_I, 4 DONE_D.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GNT_I  = 3'd1,
    S_GNT_D  = 3'd2,
    S_DONE_I = 3'd3,
    S_DONE_D = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_issued;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic [ADDR_W-1:0]    r_mem_address;
  logic [BLOCK_W-1:0]   r_mem_writedata;
  logic [BLOCK_W-1:0]   r_i_readdata;
  logic [BLOCK_W-1:0]   r_d_readdata;
  logic                 w_d_req;
  logic                 w_pick_d;
  logic                 w_done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when the dcache held the most recent grant; reset favours the dcache on the first tie.
  logic                 r_last_gnt_d;
  assign w_pick_d = w_d_req & (~i_read | ~r_last_gnt_d);
`else
  assign w_pick_d = w_d_req;
`endif

  assign w_d_req = d_read | d_write;
  // Completion needs a busy phase first, so a memory that is not yet busy is not mistaken for done.
  assign w_done  = r_issued & ~mem_busywait;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pick_d)    w_next_state = S_GNT_D;
        else if (i_read) w_next_state = S_GNT_I;
      end
      S_GNT_I:  if (w_done) w_next_state = S_DONE_I;
      S_GNT_D:  if (w_done) w_next_state = S_DONE_D;
      S_DONE_I: w_next_state = S_IDLE;
      S_DONE_D: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_issued        <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
      r_i_readdata    <= '0;
      r_d_readdata    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_gnt_d    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_d) begin
            r_mem_address   <= d_address;
            r_mem_writedata <= d_writedata;
            r_mem_write     <= d_write;
            r_mem_read      <= d_read & ~d_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_gnt_d    <= 1'b1;
`endif
          end else if (i_read) begin
            r_mem_address   <= i_address;
            r_mem_write     <= 1'b0;
            r_mem_read      <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_gnt_d    <= 1'b0;
`endif
          end
        end
        S_GNT_I, S_GNT_D: begin
          if (w_done) begin
            if (r_mem_read) begin
              if (r_state == S_GNT_I) r_i_readdata <= mem_readdata;
              else                    r_d_readdata <= mem_readdata;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_issued    <= 1'b0;
          end else if (mem_busywait) begin
            r_issued <= 1'b1;
          end
        end
        default: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign i_busywait    = i_read & (r_state != S_DONE_I) & ~reset;
  assign d_busywait    = w_d_req & (r_state != S_DONE_D) & ~reset;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_address   = r_mem_address;
  assign mem_writedata = r_mem_writedata;
  assign i_readdata    = r_i_readdata;
  assign d_readdata    = r_d_readdata;
  assign o_state       = r_state;

endmodule
